// File: rtl/fill_rect.sv
// Rectangle fill engine: draws a clipped rectangle one pixel per cycle in
// column-major order into a VGA-style plot interface, with four colouring modes.
module fill_rect #(
  parameter int SCR_W = 160,
  parameter int SCR_H = 120,
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int COL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [X_W-1:0]   x0,
  input  logic [Y_W-1:0]   y0,
  input  logic [X_W-1:0]   w,
  input  logic [Y_W-1:0]   h,
  input  logic [COL_W-1:0] colour,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [COL_W-1:0] vga_colour,
  output logic             vga_plot
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [X_W:0] X_LIMIT = (X_W+1)'(SCR_W);
  localparam logic [Y_W:0] Y_LIMIT = (Y_W+1)'(SCR_H);

  state_t           state;
  logic [Y_W-1:0]   y0_q;
  logic [X_W:0]     xe_q;
  logic [Y_W:0]     ye_q;
  logic [COL_W-1:0] col_q;
  logic [1:0]       mode_q;
  logic             plot_q;

  // End coordinates are formed one bit wider than the inputs so that the sum
  // can never wrap before it is clipped to the screen edge.
  logic [X_W:0] x_sum;
  logic [Y_W:0] y_sum;
  logic [X_W:0] xe_clip;
  logic [Y_W:0] ye_clip;
  logic         empty_rect;

  assign x_sum      = {1'b0, x0} + {1'b0, w};
  assign y_sum      = {1'b0, y0} + {1'b0, h};
  assign xe_clip    = (x_sum > X_LIMIT) ? X_LIMIT : x_sum;
  assign ye_clip    = (y_sum > Y_LIMIT) ? Y_LIMIT : y_sum;
  assign empty_rect = (w == '0) || (h == '0) ||
                      ({1'b0, x0} >= X_LIMIT) || ({1'b0, y0} >= Y_LIMIT);

  // Scan position stepping; the last row/column test is done on the
  // incremented value so it compares directly against the exclusive end.
  logic [X_W:0] x_inc;
  logic [Y_W:0] y_inc;
  logic         x_last;
  logic         y_last;

  assign x_inc  = {1'b0, vga_x} + {{X_W{1'b0}}, 1'b1};
  assign y_inc  = {1'b0, vga_y} + {{Y_W{1'b0}}, 1'b1};
  assign x_last = (x_inc == xe_q);
  assign y_last = (y_inc == ye_q);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    vga_colour = col_q;
    case (mode_q)
      2'd0:    vga_colour = col_q;
      2'd1:    vga_colour = COL_W'(vga_x);
      2'd2:    vga_colour = COL_W'(vga_y);
      default: vga_colour = (vga_x[0] ^ vga_y[0]) ? ~col_q : col_q;
    endcase
  end

  // Abort must squash the strobe in the very cycle it is raised.
  assign vga_plot = plot_q & ~abort;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      plot_q <= 1'b0;
      vga_x  <= '0;
      vga_y  <= '0;
      y0_q   <= '0;
      xe_q   <= '0;
      ye_q   <= '0;
      col_q  <= '0;
      mode_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy   <= 1'b0;
          done   <= 1'b0;
          plot_q <= 1'b0;
          if (start) begin
            vga_x  <= x0;
            vga_y  <= y0;
            y0_q   <= y0;
            xe_q   <= xe_clip;
            ye_q   <= ye_clip;
            col_q  <= colour;
            mode_q <= mode;
            if (empty_rect) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state  <= FILL;
              busy   <= 1'b1;
              plot_q <= 1'b1;
            end
          end
        end

        FILL: begin
          if (abort || (x_last && y_last)) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            plot_q <= 1'b0;
          end else if (y_last) begin
            vga_y <= y0_q;
            vga_x <= x_inc[X_W-1:0];
          end else begin
            vga_y <= y_inc[Y_W-1:0];
          end
        end

        DONE: begin
          busy   <= 1'b0;
          plot_q <= 1'b0;
          // Hold here until the requester drops start, so a held start
          // cannot launch a second fill.
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          plot_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fill_rect.sv
// Self-checking bench for fill_rect: table-driven fills against a pixel
// scoreboard, plus hand-written reset, abort and retrigger sequences.
module tb_fill_rect;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] w;
  logic [6:0] h;
  logic [2:0] colour;
  logic [1:0] mode;
  logic       busy;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  fill_rect dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .x0         (x0),
    .y0         (y0),
    .w          (w),
    .h          (h),
    .colour     (colour),
    .mode       (mode),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    x0;
    int    y0;
    int    w;
    int    h;
    int    colour;
    int    mode;
    int    exp_plots;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [17:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] model_colour(input int x, input int y, input int col, input int md);
    logic [2:0] c;
    c = 3'(col);
    case (md)
      0:       return c;
      1:       return 3'(x % 8);
      2:       return 3'(y % 8);
      default: return ((x ^ y) & 1) != 0 ? ~c : c;
    endcase
  endfunction

  // Expected pixel stream, independent of the DUT: clip, then column-major scan.
  task automatic push_expected(input vec_t v);
    int xe, ye;
    xe = (v.x0 + v.w > 160) ? 160 : v.x0 + v.w;
    ye = (v.y0 + v.h > 120) ? 120 : v.y0 + v.h;
    for (int x = v.x0; x < xe; x++)
      for (int y = v.y0; y < ye; y++)
        sb.push_back({8'(x), 7'(y), model_colour(x, y, v.colour, v.mode)});
  endtask

  task automatic drive_req(input vec_t v);
    x0     = 8'(v.x0);
    y0     = 7'(v.y0);
    w      = 8'(v.w);
    h      = 7'(v.h);
    colour = 3'(v.colour);
    mode   = 2'(v.mode);
    start  = 1'b1;
  endtask

  task automatic run_fill(input vec_t v);
    int plots    = 0;
    int cyc      = 0;
    int done_cyc = -1;
    int stray    = 0;
    logic [17:0] e;
    push_expected(v);
    @(negedge clk);
    drive_req(v);
    #1;
    check({v.name, " idle outputs"}, {29'd0, busy, done, vga_plot}, 32'd0);
    while (done_cyc < 0 && cyc < v.exp_plots + 8) begin
      @(negedge clk);
      #1;
      cyc++;
      if (vga_plot) begin
        plots++;
        if (cyc == 1) check({v.name, " busy on first plot"}, {31'd0, busy}, 32'd1);
        if (sb.size() == 0) check({v.name, " extra plot"}, {14'd0, vga_x, vga_y, vga_colour}, 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          check({v.name, " pixel"}, {14'd0, vga_x, vga_y, vga_colour}, {14'd0, e});
        end
      end
      if (done) done_cyc = cyc;
    end
    check({v.name, " plot count"}, plots, v.exp_plots);
    check({v.name, " done cycle"}, done_cyc, v.exp_plots + 1);
    check({v.name, " missing pixels"}, sb.size(), 0);
    // Start still held: DONE must persist with no new plots.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (vga_plot || busy || !done) stray++;
    end
    check({v.name, " no retrigger"}, stray, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check({v.name, " done until start low"}, {31'd0, done}, 32'd1);
    @(negedge clk);
    #1;
    check({v.name, " back to idle"}, {29'd0, busy, done, vga_plot}, 32'd0);
    sb.delete();
  endtask

  vec_t vecs[10];

  initial begin
    int n;
    int cyc;
    int abort_cyc;
    int done_cyc;
    int stray;
    logic aborted;

    vecs[0] = '{"full screen",    0,   0, 160, 120, 5, 0, 19200};
    vecs[1] = '{"clip corner",  150, 115,  20,  10, 3, 0,    50};
    vecs[2] = '{"empty w0",      10,  10,   0,   5, 1, 0,     0};
    vecs[3] = '{"empty x0 200", 200,  10,  10,   5, 1, 0,     0};
    vecs[4] = '{"empty h0",      10,  10,   5,   0, 1, 0,     0};
    vecs[5] = '{"empty y0 120",  10, 120,   5,   5, 1, 0,     0};
    vecs[6] = '{"mode1 16x2",     0,   0,  16,   2, 0, 1,    32};
    vecs[7] = '{"mode3 16x2",     0,   0,  16,   2, 2, 3,    32};
    vecs[8] = '{"mode2 y wrap",  10, 100,   2, 100, 6, 2,    40};
    vecs[9] = '{"last column",  159,   0, 255,   1, 4, 0,     1};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; colour = '0; mode = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset status", {29'd0, busy, done, vga_plot}, 32'd0);
    check("reset pixel", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_fill(vecs[i]);

    // Reset in the middle of a 20x20 fill, right after the 100th plot.
    @(negedge clk);
    drive_req('{"r", 0, 0, 20, 20, 7, 0, 400});
    n = 0;
    cyc = 0;
    while (n < 100 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
      if (vga_plot) n++;
    end
    check("plots before reset", n, 100);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    #1;
    check("mid-fill reset status", {29'd0, busy, done, vga_plot}, 32'd0);
    check("mid-fill reset pixel", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
    rst = 1'b0;
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (vga_plot || busy || done) stray++;
    end
    check("fill abandoned after reset", stray, 0);
    run_fill('{"post-reset 4x4", 3, 4, 4, 4, 1, 3, 16});

    // Abort raised on what would be plot 37 of a 10x10 fill.
    @(negedge clk);
    drive_req('{"a", 2, 3, 10, 10, 2, 2, 100});
    n = 0; cyc = 0; abort_cyc = -1; done_cyc = -1; aborted = 1'b0;
    while (done_cyc < 0 && cyc < 150) begin
      @(negedge clk);
      cyc++;
      abort = (n == 36) && !aborted;
      #1;
      if (abort) begin
        aborted = 1'b1;
        abort_cyc = cyc;
        check("plot suppressed by abort", {31'd0, vga_plot}, 32'd0);
      end
      if (vga_plot) n++;
      if (done) done_cyc = cyc;
    end
    check("abort plot count", n, 36);
    check("abort done cycle", done_cyc, abort_cyc + 1);
    // Start held and abort pulsed in DONE: no retrigger, done stays up.
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      abort = (i == 1);
      #1;
      if (vga_plot || busy || !done) stray++;
    end
    check("abort no retrigger", stray, 0);
    abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    check("abort back to idle", {29'd0, busy, done, vga_plot}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
